// File: rtl/proc_dblbuf_scheduler_pkg.sv
// Shared types and default widths for the double-buffered processor scheduler.
package proc_dblbuf_scheduler_pkg;

  localparam int unsigned IdWDef    = 16;
  localparam int unsigned StageWDef = 8;
  localparam int unsigned FixedWDef = 32;

  // Life cycle of one cache buffer.
  typedef enum logic [1:0] {
    SlotFree,
    SlotFilling,
    SlotLoaded,
    SlotEval
  } slot_state_t;

  // Job-level sequencing.
  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } sched_state_t;

  // Ping-pong partner of a buffer.
  function automatic logic other_buf(input logic b);
    return ~b;
  endfunction

endpackage

// File: rtl/proc_dblbuf_scheduler_sched_id_fifo.sv
// Two-entry FIFO of (window id, buffer) for evaluations in flight, in launch order.
module proc_dblbuf_scheduler_sched_id_fifo #(
  parameter int unsigned IdW = 16
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           push_i,
  input  logic [IdW-1:0] push_id_i,
  input  logic           push_buf_i,
  input  logic           pop_i,
  output logic [IdW-1:0] head_id_o,
  output logic           head_buf_o,
  output logic           full_o,
  output logic           empty_o
);

  logic [IdW-1:0] id_q [2];
  logic           buf_q [2];
  logic           wr_ptr_q;
  logic           rd_ptr_q;
  logic [1:0]     cnt_q;
  logic           do_push;
  logic           do_pop;

  // Overflowing pushes and underflowing pops are dropped.
  always_comb begin
    do_push = push_i && (cnt_q != 2'd2);
    do_pop  = pop_i && (cnt_q != 2'd0);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < 2; i++) begin
        id_q[i]  <= '0;
        buf_q[i] <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        id_q[wr_ptr_q]  <= push_id_i;
        buf_q[wr_ptr_q] <= push_buf_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head_id_o  = id_q[rd_ptr_q];
  assign head_buf_o = buf_q[rd_ptr_q];
  assign full_o     = (cnt_q == 2'd2);
  assign empty_o    = (cnt_q == 2'd0);

endmodule

// File: rtl/proc_dblbuf_scheduler.sv
// Ping-pong scheduler: fills one processor cache buffer while the other is evaluated,
// launches evaluations in fill order and tags each pass/fail result with its window id.
module proc_dblbuf_scheduler
  import proc_dblbuf_scheduler_pkg::*;
#(
  parameter int unsigned IdW    = IdWDef,
  parameter int unsigned StageW = StageWDef,
  parameter int unsigned FixedW = FixedWDef
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start_i,
  input  logic [IdW-1:0]    cfg_num_windows_i,
  input  logic [StageW-1:0] cfg_num_stages_i,
  input  logic [FixedW-1:0] cfg_inv_window_area_i,
  output logic              busy_o,
  output logic              job_done_o,
  output logic              fill_req_o,
  output logic              fill_buf_o,
  output logic [IdW-1:0]    fill_id_o,
  input  logic              fill_done_i,
  output logic              p_start_o,
  output logic              p_dbl_buf_o,
  output logic [StageW-1:0] p_num_stages_o,
  output logic              p_start_var_o,
  output logic              p_dbl_buf_var_o,
  output logic [FixedW-1:0] p_inv_window_area_o,
  input  logic              p_ready_i,
  input  logic              p_var_ready_i,
  input  logic              p_result_valid_i,
  input  logic              p_passfail_i,
  output logic              p_result_taken_o,
  output logic              res_valid_o,
  output logic [IdW-1:0]    res_id_o,
  output logic              res_passfail_o,
  input  logic              res_ready_i
);

  sched_state_t      state_q;
  slot_state_t       slot_q [2];
  logic [IdW-1:0]    num_q;
  logic [IdW-1:0]    issue_cnt_q;
  logic [IdW-1:0]    launch_cnt_q;
  logic [IdW-1:0]    done_cnt_q;
  logic              next_fill_q;
  logic              next_eval_q;
  logic              fill_req_q;
  logic              fill_buf_q;
  logic [IdW-1:0]    fill_id_q;
  logic              p_start_q;
  logic              p_dbl_buf_q;
  logic [StageW-1:0] p_num_stages_q;
  logic [FixedW-1:0] p_inv_q;
  logic              res_valid_q;
  logic [IdW-1:0]    res_id_q;
  logic              res_passfail_q;
  logic              job_done_q;

  logic              fill_go;
  logic              launch_go;
  logic              take;
  logic              fifo_full;
  logic              fifo_empty;
  logic [IdW-1:0]    head_id;
  logic              head_buf;

  // Event decisions for this cycle, all from registered slot states.
  always_comb begin
    fill_go   = (state_q == StRun) && !fill_req_q && (slot_q[next_fill_q] == SlotFree) &&
                (issue_cnt_q < num_q);
    launch_go = (state_q == StRun) && (slot_q[next_eval_q] == SlotLoaded) && p_ready_i &&
                p_var_ready_i && !fifo_full;
    // An empty FIFO means no evaluation is in flight, so a stray result is ignored.
    take      = p_result_valid_i && !fifo_empty && (!res_valid_q || res_ready_i);
  end

  proc_dblbuf_scheduler_sched_id_fifo #(
    .IdW (IdW)
  ) u_id_fifo (
    .clk_i      (clk),
    .reset_i    (reset),
    .push_i     (launch_go),
    .push_id_i  (launch_cnt_q),
    .push_buf_i (next_eval_q),
    .pop_i      (take),
    .head_id_o  (head_id),
    .head_buf_o (head_buf),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Job FSM, per-buffer slot FSMs, and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      slot_q[0]      <= SlotFree;
      slot_q[1]      <= SlotFree;
      num_q          <= '0;
      issue_cnt_q    <= '0;
      launch_cnt_q   <= '0;
      done_cnt_q     <= '0;
      next_fill_q    <= 1'b0;
      next_eval_q    <= 1'b0;
      fill_req_q     <= 1'b0;
      fill_buf_q     <= 1'b0;
      fill_id_q      <= '0;
      p_start_q      <= 1'b0;
      p_dbl_buf_q    <= 1'b0;
      p_num_stages_q <= '0;
      p_inv_q        <= '0;
      res_valid_q    <= 1'b0;
      res_id_q       <= '0;
      res_passfail_q <= 1'b0;
      job_done_q     <= 1'b0;
    end else begin
      job_done_q <= 1'b0;
      p_start_q  <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (cfg_start_i) begin
            num_q          <= cfg_num_windows_i;
            p_num_stages_q <= cfg_num_stages_i;
            p_inv_q        <= cfg_inv_window_area_i;
            issue_cnt_q    <= '0;
            launch_cnt_q   <= '0;
            done_cnt_q     <= '0;
            next_fill_q    <= 1'b0;
            next_eval_q    <= 1'b0;
            state_q        <= (cfg_num_windows_i == '0) ? StDone : StRun;
          end
        end
        StRun: begin
          // Finish only once the last tagged result has left the output register.
          if ((done_cnt_q == num_q) && (!res_valid_q || res_ready_i)) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          job_done_q <= 1'b1;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      // Loader handshake: one request outstanding, held until fill_done.
      if (fill_req_q) begin
        if (fill_done_i) begin
          fill_req_q         <= 1'b0;
          slot_q[fill_buf_q] <= SlotLoaded;
        end
      end else if (fill_go) begin
        fill_req_q          <= 1'b1;
        fill_buf_q          <= next_fill_q;
        fill_id_q           <= issue_cnt_q;
        issue_cnt_q         <= issue_cnt_q + IdW'(1);
        next_fill_q         <= other_buf(next_fill_q);
        slot_q[next_fill_q] <= SlotFilling;
      end

      // Launch evaluator and variance calc together on the same buffer.
      if (launch_go) begin
        p_start_q           <= 1'b1;
        p_dbl_buf_q         <= next_eval_q;
        launch_cnt_q        <= launch_cnt_q + IdW'(1);
        next_eval_q         <= other_buf(next_eval_q);
        slot_q[next_eval_q] <= SlotEval;
      end

      // Result capture into the single-entry output register.
      if (take) begin
        res_valid_q      <= 1'b1;
        res_id_q         <= head_id;
        res_passfail_q   <= p_passfail_i;
        slot_q[head_buf] <= SlotFree;
        done_cnt_q       <= done_cnt_q + IdW'(1);
      end else if (res_ready_i) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign busy_o              = (state_q != StIdle);
  assign job_done_o          = job_done_q;
  assign fill_req_o          = fill_req_q;
  assign fill_buf_o          = fill_buf_q;
  assign fill_id_o           = fill_id_q;
  assign p_start_o           = p_start_q;
  assign p_dbl_buf_o         = p_dbl_buf_q;
  assign p_num_stages_o      = p_num_stages_q;
  assign p_start_var_o       = p_start_q;
  assign p_dbl_buf_var_o     = p_dbl_buf_q;
  assign p_inv_window_area_o = p_inv_q;
  assign p_result_taken_o    = take;
  assign res_valid_o         = res_valid_q;
  assign res_id_o            = res_id_q;
  assign res_passfail_o      = res_passfail_q;

endmodule
